// File: rtl/soc_fpga_dma_pkg.sv
// Shared types and helpers for the fabric-to-SoC DMA request interface.
// Holds the FSM state encoding and the channel-index width helper.
package soc_fpga_dma_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  // Width of a channel index; never less than one bit.
  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/soc_fpga_dma_rr_arb.sv
// Combinational round-robin picker: first eligible channel strictly after
// last_grant, wrapping modulo NUM_CH.
module soc_fpga_dma_rr_arb
  import soc_fpga_dma_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [CH_W-1:0]   last_grant,
  output logic              valid,
  output logic [CH_W-1:0]   ch
);

  logic [CH_W-1:0] idx;

  always_comb begin
    valid = 1'b0;
    ch    = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = CH_W'((int'(last_grant) + k) % NUM_CH);
      if (!valid && elig[idx]) begin
        valid = 1'b1;
        ch    = idx;
      end
    end
  end

endmodule

// File: rtl/soc_fpga_intf_dma_arb.sv
// Multi-channel DMA request interface: captures fabric requests (level or
// counted edges) and serialises them onto one SoC request/ack handshake.
module soc_fpga_intf_dma_arb
  import soc_fpga_dma_pkg::*;
#(
  parameter int                NUM_CH    = 4,
  parameter int                CNT_W     = 3,
  parameter logic [NUM_CH-1:0] EDGE_MODE = '0,
  localparam int               CH_W      = ch_w(NUM_CH)
) (
  input  logic              DMA_CLK,
  input  logic              DMA_RST,
  input  logic [NUM_CH-1:0] DMA_REQ,
  output logic [NUM_CH-1:0] DMA_ACK,
  output logic [NUM_CH-1:0] DMA_OVF,
  input  logic              OVF_CLR,
  output logic              SOC_REQ,
  output logic [CH_W-1:0]   SOC_CH,
  input  logic              SOC_ACK
);

  localparam logic [CNT_W-1:0] PEND_MAX = '1;

  state_t              state, state_next;
  logic [NUM_CH-1:0]   req_q, req_qq, edge_det;
  logic [CNT_W-1:0]    pend [NUM_CH];
  logic [NUM_CH-1:0]   pend_nz, elig, dec, ovf_set;
  logic [CH_W-1:0]     last_grant, pick_ch;
  logic                pick_valid, grant, done;

  assign edge_det = req_q & ~req_qq;
  assign SOC_REQ  = (state == REQ);

  // A level channel is masked while its DMA_ACK is high, so a fabric that
  // drops its request on the ack does not get granted a second time.
  always_comb begin
    pend_nz = '0;
    for (int i = 0; i < NUM_CH; i++) pend_nz[i] = (pend[i] != '0);
    elig = (EDGE_MODE & pend_nz) | (~EDGE_MODE & req_q & ~DMA_ACK);
  end

  soc_fpga_dma_rr_arb #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_arb (
    .elig       (elig),
    .last_grant (last_grant),
    .valid      (pick_valid),
    .ch         (pick_ch)
  );

  always_comb begin
    state_next = state;
    grant      = 1'b0;
    done       = 1'b0;
    dec        = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = REQ;
          grant      = 1'b1;
        end
      end
      REQ: begin
        if (SOC_ACK) begin
          state_next  = IDLE;
          done        = 1'b1;
          dec[SOC_CH] = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge DMA_CLK) begin
    if (DMA_RST) begin
      state      <= IDLE;
      SOC_CH     <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      DMA_ACK    <= '0;
      req_q      <= '0;
      req_qq     <= '0;
    end else begin
      state   <= state_next;
      DMA_ACK <= dec;
      req_q   <= DMA_REQ;
      req_qq  <= req_q;
      if (grant) SOC_CH <= pick_ch;
      if (done) last_grant <= SOC_CH;
    end
  end

  // Overflow only on a net increment into a saturated counter.
  always_comb begin
    ovf_set = '0;
    for (int i = 0; i < NUM_CH; i++)
      ovf_set[i] = EDGE_MODE[i] && edge_det[i] && !dec[i] && (pend[i] == PEND_MAX);
  end

  always_ff @(posedge DMA_CLK) begin
    if (DMA_RST) begin
      for (int i = 0; i < NUM_CH; i++) pend[i] <= '0;
      DMA_OVF <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (EDGE_MODE[i]) begin
          if (edge_det[i] && !dec[i] && (pend[i] != PEND_MAX))
            pend[i] <= pend[i] + CNT_W'(1);
          else if (!edge_det[i] && dec[i])
            pend[i] <= pend[i] - CNT_W'(1);
        end
      end
      DMA_OVF <= ovf_set | (DMA_OVF & ~{NUM_CH{OVF_CLR}});
    end
  end

endmodule

// File: tb/tb_soc_fpga_intf_dma_arb.sv
// Directed self-checking bench: channel 0 counts edges (CNT_W=2), channels
// 1..3 are level requests.
module tb_soc_fpga_intf_dma_arb;

  logic       clk;
  logic       rst;
  logic [3:0] dma_req;
  logic [3:0] dma_ack;
  logic [3:0] dma_ovf;
  logic       ovf_clr;
  logic       soc_req;
  logic [1:0] soc_ch;
  logic       soc_ack;

  int tests_run;
  int tests_failed;

  soc_fpga_intf_dma_arb #(
    .NUM_CH    (4),
    .CNT_W     (2),
    .EDGE_MODE (4'b0001)
  ) dut (
    .DMA_CLK (clk),
    .DMA_RST (rst),
    .DMA_REQ (dma_req),
    .DMA_ACK (dma_ack),
    .DMA_OVF (dma_ovf),
    .OVF_CLR (ovf_clr),
    .SOC_REQ (soc_req),
    .SOC_CH  (soc_ch),
    .SOC_ACK (soc_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic r, input logic [3:0] req,
                               input logic ack, input logic clr);
    rst     = r;
    dma_req = req;
    soc_ack = ack;
    ovf_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n, first_cyc, last_cyc, hold, grants, acks, bad_ch, max_p;
    logic prev;
    int exp_seq [8];

    tests_run    = 0;
    tests_failed = 0;
    exp_seq      = '{3, 0, 1, 2, 3, 1, 2, 3};
    first_cyc    = 0;
    last_cyc     = 0;

    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_soc_req", 32'(soc_req), 0);
    checkOutput("rst_soc_ch", 32'(soc_ch), 0);
    checkOutput("rst_dma_ack", 32'(dma_ack), 0);
    checkOutput("rst_dma_ovf", 32'(dma_ovf), 0);
    checkOutput("rst_pend0", 32'(dut.pend[0]), 0);

    // Single level request on channel 2, acked one cycle after SOC_REQ.
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    tick();
    checkOutput("lvl_lat1", 32'(soc_req), 0);
    tick();
    checkOutput("lvl_req", 32'(soc_req), 1);
    checkOutput("lvl_ch", 32'(soc_ch), 2);
    applyStimulus(1'b0, 4'b0100, 1'b1, 1'b0);
    tick();
    checkOutput("lvl_req_drop", 32'(soc_req), 0);
    checkOutput("lvl_ack", 32'(dma_ack), 4);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("lvl_ack_once", 32'(dma_ack), 0);
    checkOutput("lvl_no_regrant", 32'(soc_req), 0);
    tick();
    checkOutput("lvl_no_regrant2", 32'(soc_req), 0);

    // Round robin with all requests high and immediate SOC_ACK.
    applyStimulus(1'b0, 4'b1111, 1'b1, 1'b0);
    n = 0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      tick();
      if (soc_req) begin
        checkOutput($sformatf("rr_ch%0d", n), 32'(soc_ch), exp_seq[n]);
        if (n == 0) first_cyc = c;
        last_cyc = c;
        n++;
      end
    end
    checkOutput("rr_grants", n, 8);
    checkOutput("rr_span", last_cyc - first_cyc, 14);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) tick();
    checkOutput("rr_idle", 32'(soc_req), 0);
    checkOutput("rr_pend0", 32'(dut.pend[0]), 0);

    // Three edge pulses on channel 0, SOC_ACK after 5 cycles of SOC_REQ.
    hold = 0; grants = 0; acks = 0; bad_ch = 0; max_p = 0; prev = 1'b0;
    for (int c = 0; c < 80; c++) begin
      applyStimulus(1'b0, (c < 6 && c % 2 == 0) ? 4'b0001 : 4'b0000,
                    hold >= 5, 1'b0);
      tick();
      if (soc_req && !prev) begin
        grants++;
        if (soc_ch != 2'd0) bad_ch++;
      end
      if (dma_ack == 4'b0001) acks++;
      else if (dma_ack != 4'b0000) bad_ch++;
      if (int'(dut.pend[0]) > max_p) max_p = int'(dut.pend[0]);
      prev = soc_req;
      hold = soc_req ? hold + 1 : 0;
    end
    checkOutput("edge_grants", grants, 3);
    checkOutput("edge_acks", acks, 3);
    checkOutput("edge_bad_ch", bad_ch, 0);
    checkOutput("edge_max_pend", max_p, 3);
    checkOutput("edge_pend_end", 32'(dut.pend[0]), 0);
    checkOutput("edge_no_ovf", 32'(dma_ovf), 0);

    // Five edges with SOC_ACK low: counter saturates and overflow sticks.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(1'b0, (c < 10 && c % 2 == 0) ? 4'b0001 : 4'b0000,
                    1'b0, 1'b0);
      tick();
    end
    checkOutput("sat_pend", 32'(dut.pend[0]), 3);
    checkOutput("sat_ovf", 32'(dma_ovf), 1);
    checkOutput("sat_req_held", 32'(soc_req), 1);
    checkOutput("sat_ch", 32'(soc_ch), 0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("ovf_clear", 32'(dma_ovf), 0);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("ovf_set_wins", 32'(dma_ovf), 1);
    checkOutput("ovf_pend", 32'(dut.pend[0]), 3);
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("ovf_sticky", 32'(dma_ovf), 1);

    // Edge arriving in the SOC_ACK cycle with pend=2 keeps the count.
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("dec_pend", 32'(dut.pend[0]), 2);
    checkOutput("dec_ack", 32'(dma_ack), 1);
    applyStimulus(1'b0, 4'b0001, 1'b0, 1'b0);
    tick();
    checkOutput("incdec_req", 32'(soc_req), 1);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("incdec_pend", 32'(dut.pend[0]), 2);
    checkOutput("incdec_ack", 32'(dma_ack), 1);
    checkOutput("incdec_req_drop", 32'(soc_req), 0);

    // Reset during a transfer on channel 3 after a completed grant on channel 2.
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b0100, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("mid_first_ch", 32'(soc_ch), 2);
    applyStimulus(1'b0, 4'b0000, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("mid_req", 32'(soc_req), 1);
    checkOutput("mid_ch", 32'(soc_ch), 3);
    checkOutput("mid_pend0", 32'(dut.pend[0]), 1);
    applyStimulus(1'b1, 4'b1011, 1'b1, 1'b0);
    tick();
    checkOutput("mid_rst_req", 32'(soc_req), 0);
    checkOutput("mid_rst_ack", 32'(dma_ack), 0);
    checkOutput("mid_rst_ch", 32'(soc_ch), 0);
    checkOutput("mid_rst_pend", 32'(dut.pend[0]), 0);
    checkOutput("mid_rst_ovf", 32'(dma_ovf), 0);
    applyStimulus(1'b0, 4'b1011, 1'b0, 1'b0);
    tick();
    checkOutput("post_rst_lat", 32'(soc_req), 0);
    tick();
    checkOutput("post_rst_req", 32'(soc_req), 1);
    checkOutput("post_rst_ch", 32'(soc_ch), 1);
    checkOutput("post_rst_edge", 32'(dut.pend[0]), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
